cipher_seq_ctrl: RTL and testbench

CIPHER_SEQ_CTRL -- requirements
Module: cipher_seq_ctrl

---
 rtl/cipher_seq_ctrl_if.sv | 10 +
 rtl/cipher_seq_ctrl.sv | 93 +++++++++
 tb/tb_cipher_seq_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_seq_ctrl_if.sv
// Byte-loading handshake between a data/key source and the cipher sequencer.
interface cipher_seq_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d_in;
    logic [7:0] key_in;

    modport master (output in_valid, output d_in, output key_in, input in_ready);
    modport slave  (input in_valid, input d_in, input key_in, output in_ready);
endinterface

// File: rtl/cipher_seq_ctrl.sv
// Sequencer for a round-iterated cipher datapath: loads a low and a high half
// over a valid/ready byte handshake, then issues NUM_ROUNDS step strobes.
module cipher_seq_ctrl #(
    parameter int NUM_ROUNDS = 8
) (
    input  logic             clka,
    input  logic             restart,
    input  logic             start,
    input  logic             encode,
    input  logic             enable,
    cipher_seq_ctrl_if.slave bus,
    output logic [7:0]       d_byte,
    output logic [7:0]       key_byte,
    output logic             ld_lo,
    output logic             ld_hi,
    output logic             step,
    output logic             dir,
    output logic [3:0]       round_cnt,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, LOAD_LO, LOAD_HI, RUN, FINISH} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    state_t state;
    logic   in_ready;
    logic   accept;

    assign in_ready     = (state == LOAD_LO) || (state == LOAD_HI);
    assign bus.in_ready = in_ready;
    assign accept       = bus.in_valid && in_ready;
    assign busy         = (state != IDLE);
    assign done         = (state == FINISH);

    // The cycle carrying ld_hi is already in RUN; step is held off there so
    // the datapath strobes never overlap and the high half lands before round 0.
    assign step = (state == RUN) && enable && !ld_hi;

    always_ff @(posedge clka) begin
        if (!restart) begin
            state     <= IDLE;
            d_byte    <= 8'h00;
            key_byte  <= 8'h00;
            ld_lo     <= 1'b0;
            ld_hi     <= 1'b0;
            dir       <= 1'b0;
            round_cnt <= 4'd0;
        end else begin
            ld_lo <= 1'b0;
            ld_hi <= 1'b0;
            if (accept) begin
                d_byte   <= bus.d_in;
                key_byte <= bus.key_in;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD_LO;
                        dir       <= encode;
                        round_cnt <= 4'd0;
                    end
                end
                LOAD_LO: begin
                    if (accept) begin
                        ld_lo <= 1'b1;
                        state <= LOAD_HI;
                    end
                end
                LOAD_HI: begin
                    if (accept) begin
                        ld_hi <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (step) begin
                        round_cnt <= round_cnt + 4'd1;
                        if (round_cnt == LAST_ROUND) begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cipher_seq_ctrl.sv
// Scoreboard bench for cipher_seq_ctrl: an 8-round and a 1-round instance,
// with expected strobe/done events queued as each operation is driven.
module tb_cipher_seq_ctrl;
    localparam int K_LO   = 0;
    localparam int K_HI   = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] d;
        logic [7:0] k;
        logic       dirv;
        logic [3:0] rc;
    } exp_t;

    logic       clka     = 1'b0;
    logic       restart  = 1'b0;
    logic       start    = 1'b0;
    logic       encode   = 1'b0;
    logic       enable   = 1'b1;
    logic       in_valid = 1'b0;
    logic       sel      = 1'b0;
    logic [7:0] d_in     = 8'h00;
    logic [7:0] key_in   = 8'h00;

    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   step_cnt = 0;
    exp_t sb[$];

    logic [7:0] a_d_byte, a_key_byte, b_d_byte, b_key_byte;
    logic       a_ld_lo, a_ld_hi, a_step, a_dir, a_busy, a_done;
    logic       b_ld_lo, b_ld_hi, b_step, b_dir, b_busy, b_done;
    logic [3:0] a_rc, b_rc;

    logic [7:0] o_d_byte, o_key_byte;
    logic       o_ld_lo, o_ld_hi, o_step, o_dir, o_busy, o_done, o_in_ready;
    logic [3:0] o_round_cnt;

    cipher_seq_ctrl_if bus_a();
    cipher_seq_ctrl_if bus_b();

    assign bus_a.in_valid = in_valid;
    assign bus_a.d_in     = d_in;
    assign bus_a.key_in   = key_in;
    assign bus_b.in_valid = in_valid;
    assign bus_b.d_in     = d_in;
    assign bus_b.key_in   = key_in;

    cipher_seq_ctrl #(.NUM_ROUNDS(8)) dut_a (
        .clka(clka), .restart(restart), .start(start && !sel), .encode(encode),
        .enable(enable), .bus(bus_a), .d_byte(a_d_byte), .key_byte(a_key_byte),
        .ld_lo(a_ld_lo), .ld_hi(a_ld_hi), .step(a_step), .dir(a_dir),
        .round_cnt(a_rc), .busy(a_busy), .done(a_done)
    );

    cipher_seq_ctrl #(.NUM_ROUNDS(1)) dut_b (
        .clka(clka), .restart(restart), .start(start && sel), .encode(encode),
        .enable(enable), .bus(bus_b), .d_byte(b_d_byte), .key_byte(b_key_byte),
        .ld_lo(b_ld_lo), .ld_hi(b_ld_hi), .step(b_step), .dir(b_dir),
        .round_cnt(b_rc), .busy(b_busy), .done(b_done)
    );

    assign o_d_byte    = sel ? b_d_byte   : a_d_byte;
    assign o_key_byte  = sel ? b_key_byte : a_key_byte;
    assign o_ld_lo     = sel ? b_ld_lo    : a_ld_lo;
    assign o_ld_hi     = sel ? b_ld_hi    : a_ld_hi;
    assign o_step      = sel ? b_step     : a_step;
    assign o_dir       = sel ? b_dir      : a_dir;
    assign o_busy      = sel ? b_busy     : a_busy;
    assign o_done      = sel ? b_done     : a_done;
    assign o_round_cnt = sel ? b_rc       : a_rc;
    assign o_in_ready  = sel ? bus_b.in_ready : bus_a.in_ready;

    initial forever #5 clka = ~clka;

    always @(posedge clka) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Observe the selected instance mid-cycle and retire scoreboard entries.
    always @(negedge clka) begin : monitor
        exp_t e;
        int   kind;
        if (restart) begin
            checks++;
            if ((o_ld_lo + o_ld_hi + o_step) > 1) begin
                errors++;
                $display("[TB] FAIL strobe_exclusive: got ld_lo=%b ld_hi=%b step=%b, required at most one", o_ld_lo, o_ld_hi, o_step);
            end
            if (o_step) begin
                checks++;
                if (o_round_cnt !== 4'(step_cnt)) begin
                    errors++;
                    $display("[TB] FAIL step_round_cnt: got %0d, required %0d", o_round_cnt, step_cnt);
                end
                step_cnt++;
            end
            if (o_ld_lo || o_ld_hi || o_done) begin
                kind = o_ld_lo ? K_LO : (o_ld_hi ? K_HI : K_DONE);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.kind != kind || e.cyc != cyc) begin
                        errors++;
                        $display("[TB] FAIL event_timing: got kind %0d at cycle %0d, required kind %0d at cycle %0d", kind, cyc, e.kind, e.cyc);
                    end else if (kind != K_DONE && (o_d_byte !== e.d || o_key_byte !== e.k)) begin
                        errors++;
                        $display("[TB] FAIL load_bytes: got %h/%h, required %h/%h", o_d_byte, o_key_byte, e.d, e.k);
                    end else if (kind == K_DONE && (o_dir !== e.dirv || o_round_cnt !== e.rc)) begin
                        errors++;
                        $display("[TB] FAIL done_state: got dir=%b rc=%0d, required dir=%b rc=%0d", o_dir, o_round_cnt, e.dirv, e.rc);
                    end
                end
            end
        end
    end

    task automatic launch(input logic enc, input logic [7:0] d0, input logic [7:0] k0, output int s);
        @(posedge clka); #1;
        s        = cyc;
        step_cnt = 0;
        start    = 1'b1;
        encode   = enc;
        in_valid = 1'b0;
        sb.push_back('{K_LO, s + 2, d0, k0, 1'b0, 4'd0});
        @(posedge clka); #1;
        start    = 1'b0;
        encode   = ~enc;
        in_valid = 1'b1;
        d_in     = d0;
        key_in   = k0;
    endtask

    task automatic send_hi(input logic [7:0] d1, input logic [7:0] k1, input int nr, input int pause,
                           input bit push_done, input logic edir, output int dc);
        @(posedge clka); #1;
        in_valid = 1'b1;
        d_in     = d1;
        key_in   = k1;
        dc       = cyc + 2 + nr + pause;
        sb.push_back('{K_HI, cyc + 1, d1, k1, 1'b0, 4'd0});
        if (push_done) sb.push_back('{K_DONE, dc, 8'h00, 8'h00, edir, 4'(nr)});
        @(posedge clka); #1;
        in_valid = 1'b0;
        d_in     = 8'h00;
        key_in   = 8'h00;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(negedge clka);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending events, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        restart = 1'b0;
        repeat (2) @(posedge clka);
        @(negedge clka);
        checks++;
        if ({o_busy, o_done, o_in_ready, o_ld_lo, o_ld_hi, o_step, o_dir} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b, required 0000000", {o_busy, o_done, o_in_ready, o_ld_lo, o_ld_hi, o_step, o_dir});
        end
        checks++;
        if (o_round_cnt !== 4'd0 || o_d_byte !== 8'h00 || o_key_byte !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_regs: got rc=%0d d=%h k=%h, required 0/00/00", o_round_cnt, o_d_byte, o_key_byte);
        end
        @(posedge clka); #1;
        restart = 1'b1;
        repeat (3) begin
            @(negedge clka);
            checks++;
            if (o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_wait: got busy=%b in_ready=%b, required 0/0", o_busy, o_in_ready);
            end
        end
    endtask

    task automatic test_nominal();
        int s, dc;
        launch(1'b1, 8'hA5, 8'h3C, s);
        send_hi(8'h5A, 8'hC3, 8, 0, 1'b1, 1'b1, dc);
        drain(40);
        @(negedge clka);
        checks++;
        if (step_cnt != 8 || o_busy !== 1'b0 || o_round_cnt !== 4'd8 || o_dir !== 1'b1) begin
            errors++;
            $display("[TB] FAIL nominal_end: got steps=%0d busy=%b rc=%0d dir=%b, required 8/0/8/1", step_cnt, o_busy, o_round_cnt, o_dir);
        end
    endtask

    task automatic test_load_stall();
        int s, dc;
        launch(1'b0, 8'h96, 8'h69, s);
        repeat (5) begin
            @(posedge clka); #1;
            in_valid = 1'b0;
            d_in     = 8'hEE;
            key_in   = 8'hEE;
            @(negedge clka);
            checks++;
            if (o_in_ready !== 1'b1 || o_ld_hi !== 1'b0 || o_d_byte !== 8'h96 || o_key_byte !== 8'h69) begin
                errors++;
                $display("[TB] FAIL load_stall: got rdy=%b ld_hi=%b d=%h k=%h, required 1/0/96/69", o_in_ready, o_ld_hi, o_d_byte, o_key_byte);
            end
        end
        send_hi(8'h0F, 8'hF0, 8, 0, 1'b1, 1'b0, dc);
        drain(40);
        checks++;
        if (step_cnt != 8) begin
            errors++;
            $display("[TB] FAIL stall_steps: got %0d, required 8", step_cnt);
        end
    endtask

    task automatic test_pause();
        int s, dc;
        launch(1'b1, 8'h12, 8'h34, s);
        send_hi(8'h56, 8'h78, 8, 3, 1'b1, 1'b1, dc);
        repeat (5) @(posedge clka);
        #1;
        enable = 1'b0;
        repeat (3) begin
            @(negedge clka);
            checks++;
            if (o_step !== 1'b0 || o_round_cnt !== 4'd4) begin
                errors++;
                $display("[TB] FAIL pause_hold: got step=%b rc=%0d, required 0/4", o_step, o_round_cnt);
            end
            @(posedge clka); #1;
        end
        enable = 1'b1;
        drain(40);
        checks++;
        if (step_cnt != 8) begin
            errors++;
            $display("[TB] FAIL pause_steps: got %0d, required 8", step_cnt);
        end
    endtask

    task automatic test_ignored_start();
        int s, dc;
        launch(1'b1, 8'hDE, 8'hAD, s);
        send_hi(8'hBE, 8'hEF, 8, 0, 1'b1, 1'b1, dc);
        repeat (4) @(posedge clka);
        #1;
        start  = 1'b1;
        encode = ~encode;
        @(posedge clka); #1;
        start = 1'b0;
        @(negedge clka);
        checks++;
        if (o_dir !== 1'b1 || o_busy !== 1'b1 || o_round_cnt !== 4'd4) begin
            errors++;
            $display("[TB] FAIL start_in_run: got dir=%b busy=%b rc=%0d, required 1/1/4", o_dir, o_busy, o_round_cnt);
        end
        repeat (dc - cyc) @(posedge clka);
        #1;
        start = 1'b1;
        @(negedge clka);
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL finish_cycle: got done=%b, required 1", o_done);
        end
        @(posedge clka); #1;
        start = 1'b0;
        repeat (2) begin
            @(negedge clka);
            checks++;
            if (o_busy !== 1'b0 || o_round_cnt !== 4'd8) begin
                errors++;
                $display("[TB] FAIL start_in_finish: got busy=%b rc=%0d, required 0/8", o_busy, o_round_cnt);
            end
        end
        drain(5);
    endtask

    task automatic test_reset_mid_run();
        int s, dc;
        launch(1'b0, 8'h01, 8'h02, s);
        send_hi(8'h03, 8'h04, 8, 0, 1'b0, 1'b0, dc);
        repeat (6) @(posedge clka);
        #1;
        restart = 1'b0;
        @(posedge clka); #1;
        restart = 1'b1;
        @(negedge clka);
        checks++;
        if (o_busy !== 1'b0 || o_round_cnt !== 4'd0 || {o_done, o_step, o_ld_lo, o_ld_hi, o_in_ready, o_dir} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_run: got busy=%b rc=%0d flags=%b, required 0/0/000000", o_busy, o_round_cnt, {o_done, o_step, o_ld_lo, o_ld_hi, o_in_ready, o_dir});
        end
        checks++;
        if (o_d_byte !== 8'h00 || step_cnt != 5) begin
            errors++;
            $display("[TB] FAIL reset_mid_regs: got d=%h steps=%0d, required 00/5", o_d_byte, step_cnt);
        end
        repeat (15) @(negedge clka);
        drain(1);
    endtask

    task automatic test_back_to_back();
        int s, dc, s2, dc2;
        launch(1'b0, 8'h11, 8'h22, s);
        send_hi(8'h33, 8'h44, 8, 0, 1'b1, 1'b0, dc);
        repeat (dc - cyc) @(posedge clka);
        #1;
        launch(1'b1, 8'h55, 8'hAA, s2);
        @(negedge clka);
        checks++;
        if (o_round_cnt !== 4'd0 || o_in_ready !== 1'b1 || o_busy !== 1'b1 || o_dir !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_start: got rc=%0d rdy=%b busy=%b dir=%b, required 0/1/1/1", o_round_cnt, o_in_ready, o_busy, o_dir);
        end
        send_hi(8'h77, 8'h88, 8, 0, 1'b1, 1'b1, dc2);
        drain(40);
        checks++;
        if (step_cnt != 8) begin
            errors++;
            $display("[TB] FAIL b2b_steps: got %0d, required 8", step_cnt);
        end
    endtask

    task automatic test_decode_one_round();
        int s, dc;
        @(posedge clka); #1;
        sel = 1'b1;
        launch(1'b0, 8'hC0, 8'hDE, s);
        send_hi(8'hBE, 8'hEF, 1, 0, 1'b1, 1'b0, dc);
        drain(20);
        @(negedge clka);
        checks++;
        if (step_cnt != 1 || o_round_cnt !== 4'd1 || o_busy !== 1'b0 || o_dir !== 1'b0) begin
            errors++;
            $display("[TB] FAIL decode_n1: got steps=%0d rc=%0d busy=%b dir=%b, required 1/1/0/0", step_cnt, o_round_cnt, o_busy, o_dir);
        end
    endtask

    initial begin
        $display("[TB] cipher_seq_ctrl bench starting");
        test_reset();
        test_nominal();
        test_load_stall();
        test_pause();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        test_decode_one_round();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
